// File: rtl/alu_seq.sv
// alu_seq: sequential, handshaked ALU execution unit for the 19-bit datapath.
//
// Accepts one operation at a time on the request channel. Logic, add, sub,
// divide-by-zero and invalid opcodes take one execute cycle. MUL (shift-add)
// and DIV (restoring) iterate one bit per cycle for WIDTH cycles. The result
// and flags are returned on the response channel.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid and ready are both 1. The requester holds opcode/r2/r3
// stable while req_valid=1. rsp_valid stays high, with r1/FLAG stable, until
// the rsp_valid & rsp_ready edge. rsp_ready seen while rsp_valid=0 is ignored.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req_valid  request present
//   req_ready  block can accept a request (IDLE only)
//   opcode     operation, sampled on request handshake
//   r2, r3     operands A and B, sampled on request handshake
//   rsp_valid  result available
//   rsp_ready  consumer takes result
//   r1         registered result
//   FLAG       registered status flags
//              {0, mul_ovf, invalid, div0, ovf, neg, carry, zero}
//
// The FSM state is held in the enumerated signal `state`.
module alu_seq #(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] r1,
  output logic [7:0]       FLAG
);

  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_SUB = 6'b000010;
  localparam logic [5:0] OP_MUL = 6'b000011;
  localparam logic [5:0] OP_DIV = 6'b000100;
  localparam logic [5:0] OP_AND = 6'b000111;
  localparam logic [5:0] OP_OR  = 6'b001000;
  localparam logic [5:0] OP_XOR = 6'b001001;
  localparam logic [5:0] OP_NOT = 6'b001011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_CALC,   // final execute cycle: writes r1/FLAG
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic               ready_en;   // keeps req_ready low until the first edge after reset
  logic [5:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc;        // MUL: {partial sum, multiplier}; DIV: {remainder, quotient}
  logic [4:0]         cnt;

  logic               req_fire;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;
  logic [WIDTH-1:0]   res;
  logic               f_carry, f_ovf, f_dz, f_inv, f_mov;
  logic [7:0]         flag_nxt;

  assign req_ready = (state == S_IDLE) && ready_en;
  assign rsp_valid = (state == S_DONE);
  assign req_fire  = req_valid && req_ready;

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_fire) begin
          if (opcode == OP_MUL)                    state_nxt = S_MUL;
          else if (opcode == OP_DIV && r3 != '0)   state_nxt = S_DIV;
          else                                     state_nxt = S_CALC;
        end
      end
      S_MUL, S_DIV: if (cnt == 5'd0) state_nxt = S_CALC;
      S_CALC:       state_nxt = S_DONE;
      S_DONE:       if (rsp_ready) state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
    end
  end

  // ---------------- iteration steps ----------------
  // Shift-add: add A into the upper half when the current multiplier LSB is
  // set, then shift the whole accumulator right by one.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);

  // Restoring division: shift the next dividend bit into the remainder and
  // subtract B; a set MSB of the difference means the subtraction borrowed.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};

  // ---------------- result and flags ----------------
  assign add_ext = {1'b0, a_q} + {1'b0, b_q};
  assign sub_ext = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    res     = '0;
    f_carry = 1'b0;
    f_ovf   = 1'b0;
    f_dz    = 1'b0;
    f_inv   = 1'b0;
    f_mov   = 1'b0;
    case (op_q)
      OP_ADD: begin
        res     = add_ext[WIDTH-1:0];
        f_carry = add_ext[WIDTH];
        f_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res     = sub_ext[WIDTH-1:0];
        f_carry = sub_ext[WIDTH];   // borrow, i.e. A < B
        f_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MUL: begin
        res   = acc[WIDTH-1:0];
        f_mov = |acc[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        if (b_q == '0) begin
          res  = '1;
          f_dz = 1'b1;
        end else begin
          res = acc[WIDTH-1:0];
        end
      end
      OP_AND:  res = a_q & b_q;
      OP_OR:   res = a_q | b_q;
      OP_XOR:  res = a_q ^ b_q;
      OP_NOT:  res = ~a_q;
      default: f_inv = 1'b1;
    endcase
    flag_nxt = {1'b0, f_mov, f_inv, f_dz, f_ovf, res[WIDTH-1], f_carry,
                (res == '0) && !f_inv};
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      cnt  <= '0;
      r1   <= '0;
      FLAG <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_fire) begin
            op_q <= opcode;
            a_q  <= r2;
            b_q  <= r3;
            cnt  <= 5'(WIDTH - 1);
            if (opcode == OP_MUL) acc <= {{WIDTH{1'b0}}, r3};
            else                  acc <= {{WIDTH{1'b0}}, r2};
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt - 5'd1;
        end
        S_DIV: begin
          if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else                  acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          cnt <= cnt - 5'd1;
        end
        S_CALC: begin
          r1   <= res;
          FLAG <= flag_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq plus hand-written sequences for
// backpressure and reset in the middle of an iterative operation.
module tb_alu_seq;
  localparam int W = 19;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [5:0]   opcode = '0;
  logic [W-1:0] r2 = '0;
  logic [W-1:0] r3 = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] r1;
  logic [7:0]   FLAG;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .opcode    (opcode),
    .r2        (r2),
    .r3        (r3),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .r1        (r1),
    .FLAG      (FLAG)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];   // expected r1 values, in issue order

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [7:0]   f;
    int           lat;
    bit           early;   // assert rsp_ready before the result is valid
    string        name;
  } vec_t;

  function automatic vec_t mkv(input logic [5:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] r,
                               input logic [7:0] f, input int lat, input bit early,
                               input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.r = r; v.f = f;
    v.lat = lat; v.early = early; v.name = name;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Issues one request, scrambles the inputs after the handshake, waits
  // (bounded) for the response, checks it and completes the handshake.
  task automatic do_op(input vec_t v);
    int cyc;
    logic [W-1:0] got;
    cyc = 0;
    @(negedge clk);
    while (!req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({v.name, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    opcode    = v.op;
    r2        = v.a;
    r3        = v.b;
    exp_q.push_back(v.r);
    @(posedge clk);            // handshake edge N
    @(negedge clk);
    req_valid = 1'b0;
    opcode    = 6'($urandom_range(0, 63));
    r2        = W'($urandom_range(0, (1 << W) - 1));
    r3        = W'($urandom_range(0, (1 << W) - 1));
    rsp_ready = v.early;
    check({v.name, ".busy"}, 32'(req_ready), 32'd0);
    cyc = 0;
    while (!rsp_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check({v.name, ".latency"}, 32'(cyc), 32'(v.lat));
    got = exp_q.pop_front();
    check({v.name, ".r1"}, 32'(r1), 32'(got));
    check({v.name, ".flag"}, 32'(FLAG), 32'(v.f));
    rsp_ready = 1'b1;
    @(posedge clk);            // response handshake edge M
    @(negedge clk);
    rsp_ready = 1'b0;
    check({v.name, ".rsp_clr"}, {30'd0, rsp_valid, req_ready}, 32'b01);
    check({v.name, ".hold"}, 32'(r1), 32'(v.r));
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int any_valid;
    logic [W-1:0] prev_r1;

    // ---------------- reset ----------------
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.req_ready", 32'(req_ready), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.r1", 32'(r1), 32'd0);
    check("rst.flag", 32'(FLAG), 32'd0);
    reset = 1'b0;
    #1 check("rst.ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rst.ready_after_edge", 32'(req_ready), 32'd1);

    // ---------------- table ----------------
    vecs.push_back(mkv(6'b000001, 19'd10, 19'd15, 19'd25, 8'h00, 1, 0, "add"));
    vecs.push_back(mkv(6'b000010, 19'd5, 19'd20, 19'h7FFF1, 8'h06, 1, 0, "sub_borrow"));
    vecs.push_back(mkv(6'b000011, 19'd3, 19'd4, 19'd12, 8'h00, 20, 0, "mul_small"));
    vecs.push_back(mkv(6'b000011, 19'd1024, 19'd1024, 19'd0, 8'h41, 20, 1, "mul_ovf"));
    vecs.push_back(mkv(6'b000100, 19'd40, 19'd8, 19'd5, 8'h00, 20, 0, "div"));
    vecs.push_back(mkv(6'b000100, 19'd10, 19'd0, 19'h7FFFF, 8'h14, 1, 0, "div_zero"));
    vecs.push_back(mkv(6'b000111, 19'h55555, 19'h66666, 19'h44444, 8'h04, 1, 0, "and"));
    vecs.push_back(mkv(6'b001000, 19'h55555, 19'h66666, 19'h77777, 8'h04, 1, 0, "or"));
    vecs.push_back(mkv(6'b001001, 19'h55555, 19'h66666, 19'h33333, 8'h00, 1, 0, "xor"));
    vecs.push_back(mkv(6'b001011, 19'h55555, 19'h66666, 19'h2AAAA, 8'h00, 1, 0, "not"));
    vecs.push_back(mkv(6'b111111, 19'h55555, 19'h66666, 19'd0, 8'h20, 1, 0, "inv_3f"));
    vecs.push_back(mkv(6'b000000, 19'd0, 19'd0, 19'd0, 8'h20, 1, 0, "inv_00"));
    vecs.push_back(mkv(6'b000001, 19'h7FFFF, 19'd1, 19'd0, 8'h03, 1, 0, "add_carry"));
    vecs.push_back(mkv(6'b000001, 19'h3FFFF, 19'd1, 19'h40000, 8'h0C, 1, 1, "add_ovf"));
    vecs.push_back(mkv(6'b000010, 19'h40000, 19'd1, 19'h3FFFF, 8'h08, 1, 0, "sub_ovf"));
    vecs.push_back(mkv(6'b000011, 19'h7FFFF, 19'h7FFFF, 19'd1, 8'h40, 20, 0, "mul_max"));
    vecs.push_back(mkv(6'b000100, 19'h7FFFF, 19'd3, 19'h2AAAA, 8'h00, 20, 1, "div_max"));
    vecs.push_back(mkv(6'b000100, 19'd7, 19'd9, 19'd0, 8'h01, 20, 0, "div_small"));

    for (int i = 0; i < vecs.size(); i++) do_op(vecs[i]);

    // ---------------- backpressure ----------------
    begin
      int cyc;
      cyc = 0;
      @(negedge clk);
      req_valid = 1'b1; opcode = 6'b000001; r2 = 19'd1; r3 = 19'd1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      while (!rsp_valid && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      check("bp.latency", 32'(cyc), 32'd1);
      for (int k = 0; k < 5; k++) begin
        req_valid = 1'($urandom_range(0, 1));
        opcode    = 6'($urandom_range(0, 63));
        r2        = W'($urandom_range(0, (1 << W) - 1));
        r3        = W'($urandom_range(0, (1 << W) - 1));
        @(negedge clk);
        check($sformatf("bp.r1[%0d]", k), 32'(r1), 32'd2);
        check($sformatf("bp.ready[%0d]", k), {30'd0, req_ready, rsp_valid}, 32'b01);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("bp.ready_after_ack", 32'(req_ready), 32'd1);
      do_op(mkv(6'b000010, 19'd100, 19'd1, 19'd99, 8'h00, 1, 0, "bp_next"));
    end

    // ---------------- reset mid-op ----------------
    @(negedge clk);
    req_valid = 1'b1; opcode = 6'b000100; r2 = 19'd40; r3 = 19'd8;
    @(posedge clk);            // accept edge N
    @(negedge clk);
    req_valid = 1'b0;
    prev_r1 = r1;
    repeat (6) @(negedge clk);
    check("rmo.busy", {30'd0, req_ready, rsp_valid}, 32'b00);
    @(posedge clk);            // edge N+7
    #1 reset = 1'b1;
    #1;
    check("rmo.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rmo.r1", 32'(r1), 32'd0);
    check("rmo.flag", 32'(FLAG), 32'd0);
    check("rmo.prev_nonzero", 32'(prev_r1 != '0), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rmo.req_ready", 32'(req_ready), 32'd1);
    any_valid = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rsp_valid) any_valid++;
    end
    check("rmo.no_stale", 32'(any_valid), 32'd0);
    do_op(mkv(6'b000001, 19'd10, 19'd15, 19'd25, 8'h00, 1, 0, "rmo_add"));

    check("sb.empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
